// File: rtl/max7219_chain_if.sv
// Serial driver for a daisy chain of MAX7219 LED drivers.
// Captures one 16-bit word per device, shifts the whole chain out MSB first
// (farthest device first), and optionally ends the frame with a LOAD pulse.
module max7219_chain_if #(
  parameter int G_NB_DEVICES      = 4,
  parameter int G_MAX_HALF_PERIOD = 4,
  parameter int G_LOAD_DURATION   = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_start,
  input  logic                         i_en_load,
  input  logic [16*G_NB_DEVICES-1:0]   i_data,
  input  logic [G_NB_DEVICES-1:0]      i_nop_mask,
  output logic                         o_busy,
  output logic                         o_done,
  output logic                         o_max7219_load,
  output logic                         o_max7219_data,
  output logic                         o_max7219_clk
);

  // state   | meaning
  // S_IDLE  | waiting for i_start, outputs quiet
  // S_SHIFT | serialising the chain, CLK low then high for every bit
  // S_LOAD  | LOAD held high to latch the shifted words
  // S_DONE  | one-cycle completion pulse, start requests ignored

  localparam int NB = 16 * G_NB_DEVICES;
  localparam int BW = $clog2(NB);
  localparam logic [BW-1:0] BIT_INIT  = BW'(NB - 1);
  localparam logic [7:0]    HALF_INIT = 8'(G_MAX_HALF_PERIOD - 1);
  localparam logic [7:0]    LOAD_INIT = 8'(G_LOAD_DURATION - 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LOAD, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [NB-1:0]           shreg_q, shreg_d;
  logic [G_NB_DEVICES-1:0] mask_q, mask_d;
  logic                    en_load_q, en_load_d;
  logic [BW-1:0]           bit_cnt_q, bit_cnt_d;
  logic [7:0]              half_cnt_q, half_cnt_d;
  logic [7:0]              load_cnt_q, load_cnt_d;
  logic                    phase_q, phase_d;
  logic [NB-1:0]           masked_data;

  // No-op words are zeroed at capture so the shifter carries final frame data
  always_comb begin
    masked_data = '0;
    for (int k = 0; k < G_NB_DEVICES; k++) begin
      masked_data[16*k +: 16] = i_nop_mask[k] ? 16'h0000 : i_data[16*k +: 16];
    end
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      mask_q     <= '0;
      en_load_q  <= 1'b0;
      bit_cnt_q  <= '0;
      half_cnt_q <= '0;
      load_cnt_q <= '0;
      phase_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      mask_q     <= mask_d;
      en_load_q  <= en_load_d;
      bit_cnt_q  <= bit_cnt_d;
      half_cnt_q <= half_cnt_d;
      load_cnt_q <= load_cnt_d;
      phase_q    <= phase_d;
    end
  end

  // Next-state logic; all timers are down-counters ending at zero
  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    mask_d     = mask_q;
    en_load_d  = en_load_q;
    bit_cnt_d  = bit_cnt_q;
    half_cnt_d = half_cnt_q;
    load_cnt_d = load_cnt_q;
    phase_d    = phase_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          shreg_d    = masked_data;
          mask_d     = i_nop_mask;
          en_load_d  = i_en_load;
          bit_cnt_d  = BIT_INIT;
          half_cnt_d = HALF_INIT;
          phase_d    = 1'b0;
          state_d    = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (half_cnt_q != 8'd0) begin
          half_cnt_d = half_cnt_q - 8'd1;
        end else if (!phase_q) begin
          phase_d    = 1'b1;
          half_cnt_d = HALF_INIT;
        end else if (bit_cnt_q == '0) begin
          phase_d = 1'b0;
          if (en_load_q) begin
            load_cnt_d = LOAD_INIT;
            state_d    = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          // next bit: DIN may only move here, at the start of a low phase
          phase_d    = 1'b0;
          half_cnt_d = HALF_INIT;
          bit_cnt_d  = bit_cnt_q - 1'b1;
          shreg_d    = shreg_q << 1;
          if (bit_cnt_q[3:0] == 4'd0) begin
            mask_d = mask_q << 1;
          end
        end
      end
      S_LOAD: begin
        if (load_cnt_q == 8'd0) begin
          state_d = S_DONE;
        end else begin
          load_cnt_d = load_cnt_q - 8'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from registers only, so reset forces them low at once
  always_comb begin
    o_busy         = (state_q == S_SHIFT) || (state_q == S_LOAD);
    o_done         = (state_q == S_DONE);
    o_max7219_load = (state_q == S_LOAD);
    o_max7219_clk  = (state_q == S_SHIFT) && phase_q;
    o_max7219_data = (state_q == S_SHIFT) && shreg_q[NB-1] && !mask_q[G_NB_DEVICES-1];
  end

endmodule

// File: tb/tb_max7219_chain_if.sv
// Directed bench for max7219_chain_if with N=2, H=2, L=3.
module tb_max7219_chain_if;

  localparam int N = 2;
  localparam int H = 2;
  localparam int L = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_start = 1'b0;
  logic          i_en_load = 1'b0;
  logic [31:0]   i_data = '0;
  logic [1:0]    i_nop_mask = '0;
  logic          o_busy, o_done, o_max7219_load, o_max7219_data, o_max7219_clk;

  int n_checks = 0;
  int n_errors = 0;

  max7219_chain_if #(
    .G_NB_DEVICES(N), .G_MAX_HALF_PERIOD(H), .G_LOAD_DURATION(L)
  ) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_en_load(i_en_load),
    .i_data(i_data), .i_nop_mask(i_nop_mask), .o_busy(o_busy), .o_done(o_done),
    .o_max7219_load(o_max7219_load), .o_max7219_data(o_max7219_data),
    .o_max7219_clk(o_max7219_clk)
  );

  always #5 clk = ~clk;

  // Monitor, sampled on the falling system clock edge
  logic        mon_clr = 1'b0;
  logic [31:0] rx;
  int          edges, busy_cyc, load_cyc, done_cnt, viol;
  logic        prev_mclk, prev_din;

  always @(negedge clk) begin
    if (mon_clr) begin
      rx = '0; edges = 0; busy_cyc = 0; load_cyc = 0; done_cnt = 0; viol = 0;
    end else begin
      if (!prev_mclk && o_max7219_clk) begin
        rx = {rx[30:0], o_max7219_data};
        edges++;
      end
      if (prev_mclk && o_max7219_clk && (prev_din !== o_max7219_data)) viol++;
      if (o_max7219_load && o_max7219_clk) viol++;
      if (o_busy) busy_cyc++;
      if (o_max7219_load) load_cyc++;
      if (o_done) done_cnt++;
    end
    prev_mclk = o_max7219_clk;
    prev_din  = o_max7219_data;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    @(negedge clk);
    mon_clr = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [31:0] d, input logic [1:0] m, input logic el);
    i_data = d; i_nop_mask = m; i_en_load = el; i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (done_cnt != 0) begin seen = 1; break; end
    end
    if (!seen) begin
      n_checks++; n_errors++;
      $display("FAIL %s timeout waiting for o_done observed=0 expected=1", tag);
    end
    repeat (4) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] exp_rx,
                             input int exp_load, input int exp_busy);
    check({tag, "_din"},   rx, exp_rx);
    check({tag, "_edges"}, 32'(edges), 32'd32);
    check({tag, "_load"},  32'(load_cyc), 32'(exp_load));
    check({tag, "_busy"},  32'(busy_cyc), 32'(exp_busy));
    check({tag, "_done"},  32'(done_cnt), 32'd1);
    check({tag, "_viol"},  32'(viol), 32'd0);
  endtask

  initial begin
    // reset state, also while clk is running
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, o_busy}, 32'd0);
    check("rst_done", {31'd0, o_done}, 32'd0);
    check("rst_load", {31'd0, o_max7219_load}, 32'd0);
    check("rst_din",  {31'd0, o_max7219_data}, 32'd0);
    check("rst_clk",  {31'd0, o_max7219_clk}, 32'd0);
    rst = 1'b0;
    clear_mon();

    // Scenario 1: with LOAD
    pulse_start(32'h0C01_0A05, 2'b00, 1'b1);
    wait_done("s1");
    check_frame("s1", 32'h0C01_0A05, 3, 131);
    check("s1_idle_din", {31'd0, o_max7219_data}, 32'd0);
    clear_mon();

    // Scenario 2: no LOAD
    pulse_start(32'h0C01_0A05, 2'b00, 1'b0);
    wait_done("s2");
    check_frame("s2", 32'h0C01_0A05, 0, 128);
    clear_mon();

    // Scenario 3: device 0 masked
    pulse_start(32'hFFFF_FFFF, 2'b01, 1'b0);
    wait_done("s3");
    check_frame("s3", 32'hFFFF_0000, 0, 128);
    clear_mon();

    // All devices masked: full frame of zeros
    pulse_start(32'h1234_5678, 2'b11, 1'b1);
    wait_done("s3b");
    check_frame("s3b", 32'h0000_0000, 3, 131);
    clear_mon();

    // Other masked device, other pattern
    pulse_start(32'h8001_7FFE, 2'b10, 1'b1);
    wait_done("s3c");
    check_frame("s3c", 32'h0000_7FFE, 3, 131);
    clear_mon();

    // Scenario 4: second start and input changes mid-frame are ignored
    pulse_start(32'hA5A5_5A5A, 2'b00, 1'b1);
    i_data = 32'h0000_0000; i_en_load = 1'b0; i_nop_mask = 2'b11;
    repeat (9) @(negedge clk);
    pulse_start(32'h1111_2222, 2'b00, 1'b0);
    wait_done("s4");
    check_frame("s4", 32'hA5A5_5A5A, 3, 131);
    clear_mon();

    // Scenario 5: asynchronous reset during bit 20
    pulse_start(32'hFFFF_FFFF, 2'b00, 1'b1);
    begin
      bit hit = 0;
      for (int i = 0; i < 500; i++) begin
        @(negedge clk);
        if (edges >= 20) begin hit = 1; break; end
      end
      check("s5_reach_bit20", {31'd0, hit}, 32'd1);
    end
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("s5_async_busy", {31'd0, o_busy}, 32'd0);
    check("s5_async_din",  {31'd0, o_max7219_data}, 32'd0);
    check("s5_async_clk",  {31'd0, o_max7219_clk}, 32'd0);
    check("s5_async_load", {31'd0, o_max7219_load}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (300) @(negedge clk);
    check("s5_no_done", 32'(done_cnt), 32'd0);
    clear_mon();
    pulse_start(32'h0C01_0A05, 2'b00, 1'b1);
    wait_done("s5");
    check_frame("s5", 32'h0C01_0A05, 3, 131);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/max7219_chain_if.md
MAX7219_CHAIN_IF -- requirements
Module: max7219_chain_if

Interface
REQ-001 The module SHALL have parameter G_NB_DEVICES, default 4, meaning the number of cascaded MAX7219 devices (legal range 1..16).
REQ-002 The module SHALL have parameter G_MAX_HALF_PERIOD, default 4, meaning clk cycles per o_max7219_clk half period (legal range 1..255).
REQ-003 The module SHALL have parameter G_LOAD_DURATION, default 4, meaning clk cycles o_max7219_load is held high (legal range 1..255).
REQ-004 The module SHALL have port clk, input, 1 bit: single system clock, all logic on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 The module SHALL have port i_start, input, 1 bit: one-cycle request to send a frame.
REQ-007 The module SHALL have port i_en_load, input, 1 bit: when high at start, emit a LOAD pulse after shifting.
REQ-008 The module SHALL have port i_data, input, 16*G_NB_DEVICES bits: one 16-bit word per device; word k is bits [16k+15:16k], and device 0 is nearest the FPGA.
REQ-009 The module SHALL have port i_nop_mask, input, G_NB_DEVICES bits: bit k high replaces word k with 0x0000 (no-op).
REQ-010 The module SHALL have port o_busy, output, 1 bit: a frame is in progress.
REQ-011 The module SHALL have port o_done, output, 1 bit: one-cycle pulse at frame end.
REQ-012 The module SHALL have port o_max7219_load, output, 1 bit: MAX7219 LOAD/CS.
REQ-013 The module SHALL have port o_max7219_data, output, 1 bit: MAX7219 DIN.
REQ-014 The module SHALL have port o_max7219_clk, output, 1 bit: MAX7219 CLK.

Function
REQ-015 The FSM SHALL have states IDLE, SHIFT, LOAD and DONE.
REQ-016 In IDLE, i_start=1 SHALL capture i_data (with the mask applied), i_en_load and i_nop_mask into internal registers and move to SHIFT.
REQ-017 o_busy SHALL be high in every cycle spent in SHIFT or LOAD, starting the cycle after i_start is sampled.
REQ-018 i_start SHALL be ignored while o_busy=1 or o_done=1; input changes after capture SHALL NOT affect the frame in progress.
REQ-019 SHIFT SHALL serialise 16*G_NB_DEVICES bits: word G_NB_DEVICES-1 first, device 0 last, each word MSB first.
REQ-020 Each bit SHALL occupy 2*G_MAX_HALF_PERIOD cycles: clk low for G_MAX_HALF_PERIOD cycles, then high for G_MAX_HALF_PERIOD cycles.
REQ-021 o_max7219_data SHALL change only at the start of a low phase and stay stable through the following high phase.
REQ-022 After the last high phase, o_max7219_clk SHALL return low; the FSM SHALL go to LOAD if the captured en_load=1, otherwise to DONE.
REQ-023 LOAD SHALL hold o_max7219_load=1 for exactly G_LOAD_DURATION cycles with o_max7219_clk=0, then go to DONE.
REQ-024 DONE SHALL last one cycle with o_done=1 and o_busy=0, then return to IDLE.
REQ-025 o_busy SHALL stay high for exactly 32*G_NB_DEVICES*G_MAX_HALF_PERIOD + en_load*G_LOAD_DURATION cycles.
REQ-026 Outside SHIFT, o_max7219_data SHALL be 0; outside LOAD, o_max7219_load SHALL be 0.
REQ-027 The bit counter SHALL be sized ceil(log2(16*G_NB_DEVICES)) bits; the half-period and load counters SHALL each be 8 bits.
REQ-028 None of the counters SHALL wrap within a frame.
REQ-029 When i_nop_mask is all ones, the frame SHALL still be sent in full and SHALL be all zeros.

Reset
REQ-030 While rst=1, the FSM SHALL be in IDLE and all outputs SHALL be 0, regardless of clk.
REQ-031 Reset asserted mid-SHIFT or mid-LOAD SHALL abort the frame immediately with no o_done pulse.
REQ-032 After reset is released, the first i_start SHALL produce a complete, correct frame.

Verification
REQ-033 Scenario 1: N=2, H=2, L=3; i_data=0x0C01_0A05, mask=00, en_load=1 -> DIN sequence 0x0C01 then 0x0A05 MSB first over 32 CLK rising edges; LOAD high for 3 cycles; o_busy high for 131 cycles; single o_done pulse.
REQ-034 Scenario 2: same as Scenario 1 but en_load=0 -> no LOAD pulse; o_busy high for 128 cycles.
REQ-035 Scenario 3: mask=01, i_data=0xFFFF_FFFF -> DIN is 16 ones then 16 zeros.
REQ-036 Scenario 4: second i_start pulse in SHIFT cycle 10 -> ignored; exactly one frame and one o_done pulse.
REQ-037 Scenario 5: rst=1 during bit 20 -> all outputs 0 asynchronously, no o_done; then a new start sends a correct full frame.
REQ-038 Scenario 6: checker samples DIN on each CLK rising edge and verifies no DIN transition occurs while CLK=1.
